dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-side bus responder for the multicycle MIPS core. It answers the core's load/store requests with a req/ack handshake and serves a word-addressed RAM with configurable read wait states. It also decodes a small MMIO window holding a free-running cycle counter and a byte-wide TX FIFO that drains to an external console sink. It sits between the core's data port and memory/peripherals, replacing a zero-latency combinational data memory.

## Interface
- AW, 10, RAM word-address bits; RAM holds 2^AW words.
- WAIT, 1, extra cycles for RAM reads; legal range 0..7.
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_i  in  1  request; initiator holds it high until ack_o.
- we_i  in  1  1 = store, 0 = load; sampled with req_i.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data.
- rdata_o  out  32  load data; valid only while ack_o = 1.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  error flag; valid only while ack_o = 1.
- tx_data_o  out  8  FIFO head byte.
- tx_valid_o  out  1  FIFO not empty.
- tx_ready_i  in  1  sink accepts the byte when tx_valid_o = 1.

## Operation
- Address map:
  - addr[31:28] = 0x0: RAM, word index addr[AW+1:2].
  - 0xF000_0000: CNT, read/write.
  - 0xF000_0004: TXD, write pushes wdata[7:0]; read returns 0.
  - 0xF000_0008: TXS, read-only.
  - Anything else is unmapped.
- FSM states IDLE, WAIT, RESP.
  - IDLE, req_i = 1: latch we/addr/wdata. RAM read with WAIT > 0 goes to WAIT with wcnt = WAIT-1; every other access goes to RESP.
  - WAIT: wcnt = 0 goes to RESP, else wcnt decrements.
  - RESP: ack_o = 1, then return to IDLE unconditionally.
- req_i is sampled only in IDLE. It is ignored in WAIT/RESP.
- Stores take effect on the sampling edge: RAM write, CNT load, or FIFO push. Load data is registered on the edge entering RESP.
- Errors: misaligned (addr[1:0] ≠ 0), unmapped, write to TXS, or push to a full FIFO.
  - The response still acks, with err_o = 1 and rdata_o = 0.
  - The access has no side effects.
- CNT: 32-bit, increments every cycle and wraps 0xFFFF_FFFF to 0. A store loads wdata and wins over the increment on that edge; counting resumes next cycle.
- TXS read value: {16'b0, count[7:0], 6'b0, full, empty}, where count = FIFO occupancy.
- FIFO pop happens when tx_valid_o && tx_ready_i.
  - Push to a full FIFO is rejected, even if a pop occurs on the same edge.
  - Push and pop together when neither full nor empty: occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- RAM contents are not reset.

## Timing
- Request sampled at edge 0:
  - Ack during cycle 1 for stores, MMIO and RAM reads with WAIT = 0.
  - Ack during cycle 1+WAIT for RAM reads.
- Next request can be sampled on the edge after the ack cycle. Back-to-back throughput is one access per 2+WAIT cycles.
- The initiator must drop req_i (or present a new request) in the cycle after ack.
- A CNT read returns the value at the sampling edge + 1 + (number of wait cycles).
- tx_valid_o rises the cycle after the push edge into an empty FIFO. tx_data_o is registered FIFO head.
- Reset values: state IDLE, ack_o 0, err_o 0, rdata_o 0, CNT 0, FIFO empty, tx_valid_o 0, tx_data_o 0.
- Reset mid-transaction aborts with no ack. A store already committed at its sampling edge stays committed.

## Structure
- Package dmem_pkg holds:
  - Address constants CNT_ADDR, TXD_ADDR, TXS_ADDR, RAM_REGION.
  - State enum {IDLE, WAIT, RESP}.
  - TXS bit positions.
- Sub-module tx_fifo: synchronous FIFO parameterised on width and depth, with push/pop/full/empty/count.
- RAM, decode, counter and FSM stay in dmem_responder.

## Test plan
- Store 0xDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 with WAIT = 2. Required: store ack 1 cycle after sample; load ack 3 cycles after sample with rdata 0xDEAD_BEEF, err 0.
- Store 0xFFFF_FFFE to CNT, then idle 2 cycles, then read CNT. Required: wrap to 0 observed, read value matches the model count, no glitch on the load edge.
- With tx_ready_i = 0, push 0x41..0x45 to TXD. Required:
  - Pushes 1-4 ack with err 0.
  - Push 5 acks with err 1.
  - TXS reads 0x0000_0402.
  - Raising tx_ready_i drains 0x41, 0x42, 0x43, 0x44 in order.
- FIFO full with tx_ready_i = 1, push on the same edge as a pop. Required: push rejected (err 1), occupancy drops to 3.
- Load from 0x0000_0002 and from 0x8000_0000. Required: both ack in 1 cycle with err 1, rdata 0, RAM unchanged.
- Assert rst during WAIT of a RAM read. Required: no ack, all outputs at reset values next cycle, next request served normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, state/selector types and decode helpers for the data-side
// bus responder.
package dmem_pkg;

   localparam logic [31:0] CNT_ADDR   = 32'hF000_0000;
   localparam logic [31:0] TXD_ADDR   = 32'hF000_0004;
   localparam logic [31:0] TXS_ADDR   = 32'hF000_0008;
   localparam logic [3:0]  RAM_REGION = 4'h0;

   localparam int TXS_EMPTY_BIT = 0;
   localparam int TXS_FULL_BIT  = 1;
   localparam int TXS_CNT_LSB   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      SEL_RAM  = 3'd0,
      SEL_CNT  = 3'd1,
      SEL_TXD  = 3'd2,
      SEL_TXS  = 3'd3,
      SEL_NONE = 3'd4
   } sel_e;

   function automatic sel_e addr_decode(input logic [31:0] addr);
      sel_e sel;
      if (addr[31:28] == RAM_REGION) begin
         sel = SEL_RAM;
      end else if (addr == CNT_ADDR) begin
         sel = SEL_CNT;
      end else if (addr == TXD_ADDR) begin
         sel = SEL_TXD;
      end else if (addr == TXS_ADDR) begin
         sel = SEL_TXS;
      end else begin
         sel = SEL_NONE;
      end
      return sel;
   endfunction

   function automatic logic [31:0] txs_word(input logic [7:0] count,
                                            input logic full,
                                            input logic empty);
      logic [31:0] w;
      w = 32'h0000_0000;
      w[TXS_CNT_LSB +: 8] = count;
      w[TXS_FULL_BIT]     = full;
      w[TXS_EMPTY_BIT]    = empty;
      return w;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port request/response bundle between the multicycle core and the
// data responder.
interface dmem_responder_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        ack_o;
   logic        err_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  rdata_o, ack_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output rdata_o, ack_o, err_o
   );
endinterface

// File: rtl/tx_fifo.sv
// Synchronous FIFO with registered storage; head is read straight from the
// storage array so it is always a registered value.
module tx_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [W-1:0]                 i_data,
   input  logic                         i_pop,
   output logic [W-1:0]                 o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == {CW{1'b0}});
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   // A full FIFO rejects a push even when a pop lands on the same edge.
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= {PW{1'b0}};
         r_rptr  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {W{1'b0}};
         end
      end else begin
         if (w_push_ok) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= r_wptr + PW'(1);
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/dmem_responder.sv
// Data-side responder: word RAM with read wait states, free-running cycle
// counter and a console TX FIFO behind a req/ack handshake.
module dmem_responder #(
   parameter int AW         = 10,
   parameter int WAIT       = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   dmem_responder_if.slave     bus,
   output logic [7:0]          tx_data_o,
   output logic                tx_valid_o,
   input  logic                tx_ready_i
);
   import dmem_pkg::*;

   localparam int         CW       = $clog2(FIFO_DEPTH+1);
   localparam bit         HAS_WAIT = (WAIT > 0);
   localparam logic [2:0] WAIT_M1  = HAS_WAIT ? 3'(WAIT - 1) : 3'd0;

   state_e        r_state;
   state_e        w_state_nxt;
   logic [2:0]    r_wcnt;
   logic [AW-1:0] r_ram_idx;
   logic [31:0]   r_cnt;
   logic [31:0]   ram [2**AW];
   logic          r_ack;
   logic          r_err;
   logic [31:0]   r_rdata;

   sel_e          w_sel;
   logic          w_fire;
   logic          w_err;
   logic          w_rd_wait;
   logic          w_ram_we;
   logic          w_cnt_we;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [AW-1:0] w_idx;
   logic          w_ack_d;
   logic          w_err_d;
   logic [31:0]   w_rdata_d;

   assign w_sel  = addr_decode(bus.addr_i);
   assign w_idx  = bus.addr_i[AW+1:2];
   assign w_fire = (r_state == IDLE) & bus.req_i & ~rst;
   // Erroring accesses are fully suppressed: no RAM write, CNT load or push.
   assign w_err  = (bus.addr_i[1:0] != 2'b00) | (w_sel == SEL_NONE)
                 | (bus.we_i & (w_sel == SEL_TXS))
                 | (bus.we_i & (w_sel == SEL_TXD) & w_full);
   assign w_ram_we  = w_fire & bus.we_i & (w_sel == SEL_RAM) & ~w_err;
   assign w_cnt_we  = w_fire & bus.we_i & (w_sel == SEL_CNT) & ~w_err;
   assign w_push    = w_fire & bus.we_i & (w_sel == SEL_TXD) & ~w_err;
   assign w_rd_wait = HAS_WAIT & ~bus.we_i & (w_sel == SEL_RAM) & ~w_err;
   assign w_pop     = tx_valid_o & tx_ready_i;

   tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (bus.wdata_i[7:0]),
      .i_pop   (w_pop),
      .o_data  (tx_data_o),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   assign tx_valid_o = ~w_empty;

   // FSM state register plus the wait counter and latched RAM index.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_wcnt    <= 3'd0;
         r_ram_idx <= {AW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         if (w_fire) begin
            r_wcnt    <= WAIT_M1;
            r_ram_idx <= w_idx;
         end else if (r_state == dmem_pkg::WAIT) begin
            r_wcnt <= r_wcnt - 3'd1;
         end else begin
            r_wcnt <= r_wcnt;
         end
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_fire) begin
               w_state_nxt = w_rd_wait ? dmem_pkg::WAIT : RESP;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         dmem_pkg::WAIT: begin
            if (r_wcnt == 3'd0) begin
               w_state_nxt = RESP;
            end else begin
               w_state_nxt = dmem_pkg::WAIT;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Response values for the cycle after this edge; CNT reads report the
   // value the counter holds during the ack cycle.
   always_comb begin
      w_ack_d   = (w_state_nxt == RESP);
      w_err_d   = 1'b0;
      w_rdata_d = 32'h0000_0000;
      if (r_state == dmem_pkg::WAIT) begin
         if (r_wcnt == 3'd0) begin
            w_rdata_d = ram[r_ram_idx];
         end else begin
            w_rdata_d = 32'h0000_0000;
         end
      end else if (w_fire) begin
         if (w_err) begin
            w_err_d = 1'b1;
         end else if (bus.we_i || w_rd_wait) begin
            w_rdata_d = 32'h0000_0000;
         end else begin
            case (w_sel)
               SEL_RAM: w_rdata_d = ram[w_idx];
               SEL_CNT: w_rdata_d = r_cnt + 32'd1;
               SEL_TXS: w_rdata_d = txs_word(8'(w_count), w_full, w_empty);
               default: w_rdata_d = 32'h0000_0000;
            endcase
         end
      end else begin
         w_err_d = 1'b0;
      end
   end

   // Registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'h0000_0000;
      end else begin
         r_ack   <= w_ack_d;
         r_err   <= w_err_d;
         r_rdata <= w_rdata_d;
      end
   end

   assign bus.ack_o   = r_ack;
   assign bus.err_o   = r_err;
   assign bus.rdata_o = r_rdata;

   // Cycle counter; a store wins over the increment on its edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 32'h0000_0000;
      end else if (w_cnt_we) begin
         r_cnt <= bus.wdata_i;
      end else begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         ram[w_idx] <= bus.wdata_i;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues expected responses,
// independent monitors check bus acks and TX FIFO drains.
module tb_dmem_responder;
   localparam logic [31:0] CNT_A = 32'hF000_0000;
   localparam logic [31:0] TXD_A = 32'hF000_0004;
   localparam logic [31:0] TXS_A = 32'hF000_0008;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   dmem_responder_if bus();

   dmem_responder #(.AW(10), .WAIT(2), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   exp_t       q[$];
   logic [7:0] txq[$];
   int         checks = 0;
   int         errors = 0;
   time        t_sample = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Bus response monitor
   always @(negedge clk) begin
      if (bus.ack_o === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
         end else begin
            exp_t e;
            int   lat;
            e   = q.pop_front();
            lat = int'(($time - t_sample - 5) / 10) + 1;
            chk({e.name, "_rdata"}, bus.rdata_o, e.rdata);
            chk({e.name, "_err"}, {31'd0, bus.err_o}, {31'd0, e.err});
            chk({e.name, "_lat"}, lat, e.lat);
         end
      end
   end

   // TX drain monitor, sampled just before the edge that pops
   always begin
      @(negedge clk);
      #3;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         if (txq.size() == 0) begin
            chk("unexpected_tx", 32'd1, 32'd0);
         end else begin
            logic [7:0] b;
            b = txq.pop_front();
            chk("tx_byte", {24'd0, tx_data}, {24'd0, b});
         end
      end
   end

   task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input logic pop_at_sample);
      exp_t e;
      bit   got;
      e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.name = name;
      q.push_back(e);
      @(negedge clk); #1;
      bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wdata;
      if (pop_at_sample) tx_ready = 1'b1;
      @(posedge clk);
      t_sample = $time;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (pop_at_sample) tx_ready = 1'b0;
         if (bus.ack_o === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      bus.req_i = 1'b0;
      if (!got) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
         if (q.size() > 0) void'(q.pop_back());
      end
   endtask

   task automatic drain(input string name);
      tx_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (tx_valid !== 1'b1) break;
      end
      tx_ready = 1'b0;
      chk(name, txq.size(), 32'd0);
   endtask

   initial begin
      rst = 1'b1; tx_ready = 1'b0;
      bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'd0; bus.wdata_i = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", {31'd0, bus.ack_o}, 32'd0);
      chk("rst_err", {31'd0, bus.err_o}, 32'd0);
      chk("rst_rdata", bus.rdata_o, 32'd0);
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      #1 rst = 1'b0;

      // RAM store then load with two wait states
      do_req("st_ram", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, 1, 1'b0);
      do_req("ld_ram", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);

      // CNT load near wrap; read sampled 4 edges after the store edge
      do_req("st_cnt", 1'b1, CNT_A, 32'hFFFF_FFFE, 32'd0, 1'b0, 1, 1'b0);
      repeat (2) @(negedge clk);
      do_req("ld_cnt", 1'b0, CNT_A, 32'd0, 32'h0000_0002, 1'b0, 1, 1'b0);

      // TX FIFO fill with the sink stalled
      do_req("txs_empty", 1'b0, TXS_A, 32'd0, 32'h0000_0001, 1'b0, 1, 1'b0);
      do_req("push_41", 1'b1, TXD_A, 32'h0000_0041, 32'd0, 1'b0, 1, 1'b0);
      txq.push_back(8'h41);
      chk("tx_valid_rise", {31'd0, tx_valid}, 32'd1);
      chk("tx_head", {24'd0, tx_data}, 32'h41);
      for (int i = 1; i < 4; i++) begin
         do_req("push", 1'b1, TXD_A, 32'h41 + i, 32'd0, 1'b0, 1, 1'b0);
         txq.push_back(8'(8'h41 + i));
      end
      do_req("push_full", 1'b1, TXD_A, 32'h0000_0045, 32'd0, 1'b1, 1, 1'b0);
      do_req("txs_full", 1'b0, TXS_A, 32'd0, 32'h0000_0402, 1'b0, 1, 1'b0);
      do_req("ld_txd", 1'b0, TXD_A, 32'd0, 32'd0, 1'b0, 1, 1'b0);
      drain("drain1");

      // Push into a full FIFO on the same edge as a pop
      for (int i = 0; i < 4; i++) begin
         do_req("refill", 1'b1, TXD_A, 32'h51 + i, 32'd0, 1'b0, 1, 1'b0);
         txq.push_back(8'(8'h51 + i));
      end
      do_req("push_full_pop", 1'b1, TXD_A, 32'h0000_0055, 32'd0, 1'b1, 1, 1'b1);
      do_req("txs_3", 1'b0, TXS_A, 32'd0, 32'h0000_0300, 1'b0, 1, 1'b0);
      drain("drain2");

      // Error accesses leave RAM untouched
      do_req("st_ram0", 1'b1, 32'h0000_0000, 32'h1234_5678, 32'd0, 1'b0, 1, 1'b0);
      do_req("ld_misal", 1'b0, 32'h0000_0002, 32'd0, 32'd0, 1'b1, 1, 1'b0);
      do_req("ld_unmap", 1'b0, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1, 1'b0);
      do_req("st_misal", 1'b1, 32'h0000_0002, 32'h0000_0BAD, 32'd0, 1'b1, 1, 1'b0);
      do_req("st_txs", 1'b1, TXS_A, 32'h0000_0007, 32'd0, 1'b1, 1, 1'b0);
      do_req("ld_ram0", 1'b0, 32'h0000_0000, 32'd0, 32'h1234_5678, 1'b0, 3, 1'b0);

      // Reset during the WAIT phase of a RAM read aborts without ack
      @(negedge clk); #1;
      bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0000_0010;
      @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1; bus.req_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_ack", {31'd0, bus.ack_o}, 32'd0);
      chk("abort_err", {31'd0, bus.err_o}, 32'd0);
      chk("abort_rdata", bus.rdata_o, 32'd0);
      chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      do_req("ld_after_rst", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
      do_req("txs_after_rst", 1'b0, TXS_A, 32'd0, 32'h0000_0001, 1'b0, 1, 1'b0);

      repeat (4) @(negedge clk);
      chk("pending_resp", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
